a2b_conv_seq: RTL and testbench

// - Iterative arithmetic-to-Boolean (A2B) mask converter. It is the reverse direction of the B2A path.
// - Input: N_SHARES arithmetic shares, sum mod 2^K_WIDTH.
// - Output: N_SHARES Boolean shares, XOR of shares equals the same value.
// - Sequentially adds each arithmetic share into a Boolean-masked accumulator using one SecAND instance
//   (1-cycle registered latency) inside a masked ripple-carry loop.

---
 rtl/a2b_conv_seq.sv | 215 +++++++++++++++++++++
 tb/tb_a2b_conv_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/a2b_conv_seq.sv
// a2b_conv_seq: iterative arithmetic-to-Boolean mask converter.
// Each arithmetic share is added into a Boolean-masked accumulator with a
// masked ripple-carry adder: G = acc & B from one SecAND pass, then K-1 passes
// of C = (G ^ (P & C)) << 1, sum = P ^ C. A single shared SecAND (one-cycle
// registered latency) does every masked AND.
// Optional build macro A2B_OUT_REFRESH_EN: adds port rnd_ref and a REFRESH
// state that re-masks the final shares before they are presented on z.

// Masked AND over N Boolean shares with a one-cycle registered latency.
// Every cross product x_i & y_j is blinded by two random words; each word
// lands in exactly two output shares, so it cancels in the XOR of z.
module a2b_secand #(
  parameter int K = 32,
  parameter int N = 3,
  parameter int R = N * (N - 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                dvld,
  input  logic [N-1:0][K-1:0] x,
  input  logic [N-1:0][K-1:0] y,
  input  logic [K*R-1:0]      rnd,
  output logic [N-1:0][K-1:0] z,
  output logic                ovld
);
  logic [R-1:0][K-1:0] rw;
  logic [N-1:0][K-1:0] zc;

  assign rw = rnd;

  for (genvar i = 0; i < N; i++) begin : g_row
    logic [N:0][K-1:0] s;
    assign s[0] = '0;
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == i) begin : g_diag
        assign s[j+1] = s[j] ^ (x[i] & y[i]);
      end else begin : g_cross
        localparam int IJ = i * (N - 1) + ((j < i) ? j : j - 1);
        localparam int JI = j * (N - 1) + ((i < j) ? i : i - 1);
        assign s[j+1] = s[j] ^ (x[i] & y[j]) ^ rw[IJ] ^ rw[JI];
      end
    end
    assign zc[i] = s[N];
  end

  // Output share register; held whenever ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      z    <= '0;
      ovld <= 1'b0;
    end else if (ena) begin
      ovld <= dvld;
      if (dvld) z <= zc;
    end
  end
endmodule

module a2b_conv_seq #(
  parameter int K_WIDTH   = 32,
  parameter int N_SHARES  = 3,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
  parameter int RANDNUM   = N_SHARES * (N_SHARES - 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic                         dvld,
  input  logic [K_WIDTH*RANDNUM-1:0]   rnd,
`ifdef A2B_OUT_REFRESH_EN
  input  logic [K_WIDTH*(N_SHARES-1)-1:0] rnd_ref,
`endif
  input  logic [MASKWIDTH-1:0]         a,
  output logic                         busy,
  output logic [MASKWIDTH-1:0]         z,
  output logic                         ovld
);
  localparam int KW = $clog2(N_SHARES);
  localparam int IW = $clog2(K_WIDTH);

  typedef logic [N_SHARES-1:0][K_WIDTH-1:0] shares_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_G_ISS, S_G_CAP, S_C_ISS, S_C_CAP, S_SUM, S_REFRESH, S_DONE
  } state_t;

  state_t         state, state_nx;
  shares_t        a_st, acc, g, c, p, bsh, gx, cnx, sec_x, sec_y, sec_z;
  logic           sec_vld, sec_ovld;
  logic [KW-1:0]  k;
  logic [IW-1:0]  it;
  logic           last_k, last_it;

  // B is the trivial Boolean sharing of a_k: share k carries a_k, others zero.
  for (genvar i = 0; i < N_SHARES; i++) begin : g_share
    assign bsh[i] = (k == KW'(i)) ? a_st[i] : '0;
    // Carry update: drop the MSB, shift a zero into bit 0.
    assign cnx[i] = {gx[i][K_WIDTH-2:0], 1'b0};
  end

  assign p       = acc ^ bsh;
  assign gx      = g ^ sec_z;
  assign last_k  = (k == KW'(N_SHARES - 1));
  assign last_it = (it == IW'(K_WIDTH - 2));
  assign busy    = (state != S_IDLE);

  // G pass ANDs acc with B; carry passes AND the propagate vector with C.
  assign sec_x = (state == S_C_ISS) ? p : acc;
  assign sec_y = (state == S_C_ISS) ? c : bsh;

`ifdef A2B_OUT_REFRESH_EN
  // Re-mask: first N-1 shares take fresh words, the last absorbs their XOR.
  logic [N_SHARES-2:0][K_WIDTH-1:0] rref;
  logic [N_SHARES-1:0][K_WIDTH-1:0] rsum;
  shares_t                          acc_ref;
  assign rref    = rnd_ref;
  assign rsum[0] = '0;
  for (genvar i = 0; i < N_SHARES - 1; i++) begin : g_ref
    assign rsum[i+1]  = rsum[i] ^ rref[i];
    assign acc_ref[i] = acc[i] ^ rref[i];
  end
  assign acc_ref[N_SHARES-1] = acc[N_SHARES-1] ^ rsum[N_SHARES-1];
`endif

  a2b_secand #(.K(K_WIDTH), .N(N_SHARES), .R(RANDNUM)) u_secand (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .dvld (sec_vld),
    .x    (sec_x),
    .y    (sec_y),
    .rnd  (rnd),
    .z    (sec_z),
    .ovld (sec_ovld)
  );

  // State register; ena low freezes the sequence.
  always_ff @(posedge clk) begin
    if (rst)      state <= S_IDLE;
    else if (ena) state <= state_nx;
  end

  // Next-state and SecAND issue strobe.
  always_comb begin
    state_nx = state;
    sec_vld  = 1'b0;
    case (state)
      S_IDLE:  if (dvld) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_G_ISS;
      S_G_ISS: begin
        sec_vld  = 1'b1;
        state_nx = S_G_CAP;
      end
      S_G_CAP: if (sec_ovld) state_nx = S_C_ISS;
      S_C_ISS: begin
        sec_vld  = 1'b1;
        state_nx = S_C_CAP;
      end
      S_C_CAP: if (sec_ovld) state_nx = last_it ? S_SUM : S_C_ISS;
      S_SUM: begin
        if (!last_k)  state_nx = S_G_ISS;
`ifdef A2B_OUT_REFRESH_EN
        else          state_nx = S_REFRESH;
`else
        else          state_nx = S_DONE;
`endif
      end
      S_REFRESH: state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Operand store, accumulator, carry chain and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_st <= '0;
      acc  <= '0;
      g    <= '0;
      c    <= '0;
      k    <= '0;
      it   <= '0;
      z    <= '0;
      ovld <= 1'b0;
    end else if (ena) begin
      ovld <= (state == S_DONE);
      case (state)
        S_IDLE: if (dvld) a_st <= a;
        S_LOAD: begin
          acc    <= '0;
          acc[0] <= a_st[0];
          k      <= KW'(1);
        end
        S_G_CAP: if (sec_ovld) begin
          g  <= sec_z;
          c  <= '0;
          it <= '0;
        end
        S_C_CAP: if (sec_ovld) begin
          c  <= cnx;
          it <= it + 1'b1;
        end
        S_SUM: begin
          acc <= p ^ c;
          k   <= k + 1'b1;
        end
`ifdef A2B_OUT_REFRESH_EN
        S_REFRESH: acc <= acc_ref;
`endif
        S_DONE: z <= acc;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_a2b_conv_seq.sv
// tb_a2b_conv_seq: scoreboard bench for a2b_conv_seq at K=8, N=3.
module tb_a2b_conv_seq;
  localparam int K  = 8;
  localparam int N  = 3;
  localparam int R  = N * (N - 1);
  localparam int MW = K * N;
`ifdef A2B_OUT_REFRESH_EN
  localparam int LAT = 37;
`else
  localparam int LAT = 36;
`endif

  logic          clk, rst, ena, dvld, busy, ovld;
  logic [K*R-1:0] rnd;
  logic [MW-1:0] a, z;
`ifdef A2B_OUT_REFRESH_EN
  logic [K*(N-1)-1:0] rnd_ref;
`endif

  typedef struct {
    logic [7:0] val;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         wcnt = 0;
  int         acc_w = 0;
  logic [63:0] rr;
  logic [MW-1:0] z1, z2;

  a2b_conv_seq #(.K_WIDTH(K), .N_SHARES(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .dvld    (dvld),
    .rnd     (rnd),
`ifdef A2B_OUT_REFRESH_EN
    .rnd_ref (rnd_ref),
`endif
    .a       (a),
    .busy    (busy),
    .z       (z),
    .ovld    (ovld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) wcnt <= wcnt + 1;

  // Fresh randomness every cycle.
  always @(negedge clk) begin
    rr  = {$urandom, $urandom};
    rnd = rr[K*R-1:0];
`ifdef A2B_OUT_REFRESH_EN
    rnd_ref = 16'($urandom);
`endif
  end

  function automatic logic [7:0] xz(input logic [MW-1:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every ovld must match the oldest pending expectation.
  always @(negedge clk) begin
    if (ovld) begin
      if (sb.size() == 0) begin
        chk("spurious_ovld", 32'(ovld), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("xor_z", 32'(xz(z)), 32'(e.val));
        chk("latency", 32'(wcnt - acc_w), 32'(e.lat));
        chk("busy_at_ovld", 32'(busy), 32'd0);
      end
    end
  end

  // Drive one accept; extra = stalled cycles expected on top of LAT.
  task automatic start(input logic [23:0] av, input int extra);
    logic [7:0] s;
    exp_t       x;
    s = av[7:0] + av[15:8] + av[23:16];
    x.val = s;
    x.lat = LAT + extra;
    @(negedge clk);
    a    = av;
    dvld = 1'b1;
    sb.push_back(x);
    @(posedge clk);
    #1 acc_w = wcnt;
    @(negedge clk);
    dvld = 1'b0;
    a    = 24'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; dvld = 1'b0; a = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovld", 32'(ovld), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    rst = 1'b0;

    // Basic, wrap and full carry chain.
    start(24'hF00510, 0);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("z_hold", 32'(xz(z)), 32'h05);
    start(24'h0001FF, 0);
    wait_idle();
    start(24'h00017F, 0);
    wait_idle();

    // Ten-cycle stall inside the first carry loop.
    start(24'h3C_A7_59, 10);
    repeat (8) @(negedge clk);
    ena = 1'b0;
    repeat (10) @(negedge clk);
    ena = 1'b1;
    wait_idle();

    // dvld while busy must be ignored.
    start(24'h11_22_33, 0);
    repeat (4) @(negedge clk);
    dvld = 1'b1; a = 24'hFFFFFF;
    @(negedge clk);
    dvld = 1'b0;
    repeat (14) @(negedge clk);
    dvld = 1'b1; a = 24'h808080;
    @(negedge clk);
    dvld = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // Reset aborts a conversion.
    start(24'h12_34_56, 0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_z", 32'(z), 32'd0);
    chk("abort_ovld", 32'(ovld), 32'd0);
    repeat (45) @(negedge clk);
    start(24'h9A_BC_DE, 0);
    wait_idle();

    // Same input, different randomness: same XOR, different shares.
    start(24'h5A_C3_7E, 0);
    wait_idle();
    z1 = z;
    start(24'h5A_C3_7E, 0);
    wait_idle();
    z2 = z;
    chk("shares_differ", 32'(z1 != z2), 32'd1);

    // Random vectors.
    for (int i = 0; i < 1000; i++) begin
      start(24'($urandom), 0);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
